// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes 11-bit frames and queues scan codes in a FIFO.
// Optional define PS2_PARITY_CHECK_EN rejects frames whose odd-parity bit does not match the data byte.
module ps2_receiver #(
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);
   localparam logic [WDW-1:0] WD_ONE   = WDW'(1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic           clkSync1_q, clkSync2_q, clkHist_q;
   logic           dataSync1_q, dataSync2_q;
   logic           fallEdge;

   state_t         state_q, state_d;
   logic [2:0]     bitCnt_q, bitCnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [WDW-1:0] wdCnt_q, wdCnt_d;
   logic           frameErr_q, frameErr_d;
   logic           push;
   logic           frameValid;
`ifdef PS2_PARITY_CHECK_EN
   logic           parity_q, parity_d;
`endif

   logic [7:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]  wrPtr_q, rdPtr_q;
   logic [CW-1:0]  count_q;
   logic           overflow_q;
   logic           doPop, doPush, full;

   // Two-flop synchronisers; the history flop turns a high-to-low PS/2 clock into a single-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clkSync1_q  <= 1'b0;
         clkSync2_q  <= 1'b0;
         clkHist_q   <= 1'b0;
         dataSync1_q <= 1'b0;
         dataSync2_q <= 1'b0;
      end else begin
         clkSync1_q  <= ps2_clk;
         clkSync2_q  <= clkSync1_q;
         clkHist_q   <= clkSync2_q;
         dataSync1_q <= ps2_data;
         dataSync2_q <= dataSync1_q;
      end
   end

   assign fallEdge = !clkSync2_q && clkHist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         wdCnt_q    <= '0;
         frameErr_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         shift_q    <= shift_d;
         wdCnt_q    <= wdCnt_d;
         frameErr_q <= frameErr_d;
`ifdef PS2_PARITY_CHECK_EN
         parity_q   <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      shift_d    = shift_q;
      wdCnt_d    = '0;
      frameErr_d = 1'b0;
      push       = 1'b0;
      frameValid = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_d   = parity_q;
`endif

      if (state_q != IDLE && !fallEdge) wdCnt_d = wdCnt_q + WD_ONE;

      case (state_q)
         IDLE: begin
            // A high data bit on an edge is line noise, not a start bit.
            if (fallEdge && !dataSync2_q) begin
               state_d  = DATA;
               bitCnt_d = '0;
            end
         end
         DATA: begin
            if (fallEdge) begin
               shift_d  = {dataSync2_q, shift_q[7:1]};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fallEdge) begin
`ifdef PS2_PARITY_CHECK_EN
               parity_d = dataSync2_q;
`endif
               state_d = STOP;
            end
         end
         STOP: begin
            if (fallEdge) begin
`ifdef PS2_PARITY_CHECK_EN
               frameValid = dataSync2_q && (^{shift_q, parity_q});
`else
               frameValid = dataSync2_q;
`endif
               push       = frameValid;
               frameErr_d = !frameValid;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A stalled keyboard must not leave the deframer stuck mid-frame.
      if (state_q != IDLE && !fallEdge && wdCnt_q == WD_LIMIT) begin
         state_d    = IDLE;
         shift_d    = '0;
         wdCnt_d    = '0;
         frameErr_d = 1'b1;
      end
   end

   assign full   = (count_q == CNT_FULL);
   assign doPop  = !nextdata_n && (count_q != '0);
   assign doPush = push && (!full || doPop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (doPush) begin
            mem_q[wrPtr_q] <= shift_q;
            wrPtr_q        <= wrPtr_q + PTR_ONE;
         end
         if (doPop) rdPtr_q <= rdPtr_q + PTR_ONE;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         if (push && full && !doPop) overflow_q <= 1'b1;
      end
   end

   assign data      = mem_q[rdPtr_q];
   assign ready     = (count_q != '0);
   assign overflow  = overflow_q;
   assign frame_err = frameErr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed testbench for ps2_receiver: drives PS/2 frames bit by bit and checks the FIFO outputs.
module tb_ps2_receiver;

   localparam int TIMEOUT = 300;

   logic       clk;
   logic       rst_n;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   int testCount = 0;
   int failCount = 0;
   int errPulses = 0;
   int errRun    = 0;
   int errMaxRun = 0;

   ps2_receiver #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdata_n (nextdata_n),
      .data       (data),
      .ready      (ready),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts frame_err pulses and remembers the longest high run.
   always @(posedge clk) begin
      if (frame_err) begin
         if (errRun == 0) errPulses++;
         errRun++;
         if (errRun > errMaxRun) errMaxRun = errRun;
      end else begin
         errRun = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sendBit(input logic b);
      ps2_data = b;
      waitClk(5);
      ps2_clk = 1'b0;
      waitClk(10);
      ps2_clk = 1'b1;
      waitClk(5);
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit goodParity);
      logic par;
      par = goodParity ? ~^b : ^b;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(b[i]);
      sendBit(par);
      sendBit(1'b1);
      waitClk(3);
   endtask

   task automatic popOnce();
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      waitClk(3);
      rst_n = 1'b1;
      waitClk(3);
   endtask

   initial begin
      int errBase;
      logic [7:0] expByte;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      nextdata_n = 1'b1;
      rst_n      = 1'b0;
      waitClk(4);
      checkOutput("reset_ready", {31'd0, ready}, 32'd0);
      checkOutput("reset_data", {24'd0, data}, 32'h00);
      checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
      checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
      rst_n = 1'b1;
      waitClk(4);

      // Single byte then pop
      applyStimulus(8'h1C, 1'b1);
      checkOutput("t1_ready", {31'd0, ready}, 32'd1);
      checkOutput("t1_data", {24'd0, data}, 32'h1C);
      popOnce();
      checkOutput("t1_ready_after_pop", {31'd0, ready}, 32'd0);

      // Two bytes, ordered pops
      applyStimulus(8'hF0, 1'b1);
      applyStimulus(8'h1C, 1'b1);
      checkOutput("t2_ready", {31'd0, ready}, 32'd1);
      checkOutput("t2_head", {24'd0, data}, 32'hF0);
      popOnce();
      checkOutput("t2_second", {24'd0, data}, 32'h1C);
      popOnce();
      checkOutput("t2_empty", {31'd0, ready}, 32'd0);
      checkOutput("t2_overflow", {31'd0, overflow}, 32'd0);
      checkOutput("t2_err_pulses", errPulses, 32'd0);

      // Spurious edge with data high while idle is ignored
      sendBit(1'b1);
      waitClk(3);
      checkOutput("spurious_ready", {31'd0, ready}, 32'd0);
      checkOutput("spurious_err", errPulses, 32'd0);

      // Fill the FIFO and overflow it
      for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("t3_no_overflow_at_full", {31'd0, overflow}, 32'd0);
      applyStimulus(8'h09, 1'b1);
      checkOutput("t3_overflow", {31'd0, overflow}, 32'd1);
      for (int i = 1; i <= 8; i++) begin
         expByte = 8'(i);
         checkOutput($sformatf("t3_pop%0d", i), {23'd0, ready, data}, {23'd0, 1'b1, expByte});
         popOnce();
      end
      checkOutput("t3_empty", {31'd0, ready}, 32'd0);
      checkOutput("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

      // Bad parity frame
      doReset();
      checkOutput("rst_clears_overflow", {31'd0, overflow}, 32'd0);
      errBase = errPulses;
      applyStimulus(8'h1C, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      checkOutput("par_err_pulse", errPulses - errBase, 32'd1);
      checkOutput("par_err_width", errMaxRun, 32'd1);
      checkOutput("par_ready", {31'd0, ready}, 32'd0);
`else
      checkOutput("par_ignored_err", errPulses - errBase, 32'd0);
      checkOutput("par_ignored_ready", {31'd0, ready}, 32'd1);
      checkOutput("par_ignored_data", {24'd0, data}, 32'h1C);
      popOnce();
`endif

      // Bad stop bit always rejects
      errBase = errPulses;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      waitClk(3);
      checkOutput("stop_err_pulse", errPulses - errBase, 32'd1);
      checkOutput("stop_ready", {31'd0, ready}, 32'd0);

      // Watchdog abandons a stalled frame
      errBase = errPulses;
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'b1);
      waitClk(TIMEOUT + 20);
      checkOutput("wd_err_pulse", errPulses - errBase, 32'd1);
      checkOutput("wd_err_width", errMaxRun, 32'd1);
      checkOutput("wd_ready", {31'd0, ready}, 32'd0);
      applyStimulus(8'h32, 1'b1);
      checkOutput("wd_next_ready", {31'd0, ready}, 32'd1);
      checkOutput("wd_next_data", {24'd0, data}, 32'h32);
      popOnce();

      // Reset mid-frame
      sendBit(1'b0);
      for (int i = 0; i < 3; i++) sendBit(1'b1);
      doReset();
      errBase = errPulses;
      applyStimulus(8'h1C, 1'b1);
      checkOutput("rstmid_ready", {31'd0, ready}, 32'd1);
      checkOutput("rstmid_data", {24'd0, data}, 32'h1C);
      checkOutput("rstmid_no_err", errPulses - errBase, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
